// File: rtl/freq_det_pkg.sv
// -----------------------------------------------------------------------------
// freq_det_pkg
// Shared definitions for the divided-clock ratio detector: the measurement FSM
// state type and the default counter width / lock depth used by
// freq_ratio_detect.
// -----------------------------------------------------------------------------
package freq_det_pkg;

   localparam int DEF_CNT_W    = 8;  // period / high-time counter width
   localparam int DEF_LOCK_CNT = 2;  // consecutive equal periods needed for lock

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,  // waiting for the first rising edge of div_in
      ST_MEASURE = 2'd1,  // measuring periods, not yet locked
      ST_LOCKED  = 2'd2   // LOCK_CNT consecutive equal periods observed
   } state_t;

endpackage

// File: rtl/freq_edge_sync.sv
// -----------------------------------------------------------------------------
// freq_edge_sync
// Samples the divided clock and flags its rising edges in the clk domain.
//
// Build option FREQ_DET_SYNC_EN:
//   defined   - div_in passes through a 2-flop synchronizer first (adds two
//               cycles of latency, measured periods are unaffected).
//   undefined - div_in must already be synchronous to clk; only the
//               edge-detect flop samples it.
//
// Ports
//   clk    in  base clock, rising edge
//   reset  in  asynchronous, active-low reset
//   din    in  divided clock under measurement
//   lvl    out sampled level of din used by the measurement logic
//   rise   out high in the cycle where lvl=1 and the previous sample was 0
// -----------------------------------------------------------------------------
module freq_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic lvl,
   output logic rise
);

   logic prev_q, prev_d;

`ifdef FREQ_DET_SYNC_EN
   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign lvl = sync_q;
`else
   assign lvl = din;
`endif

   always_comb prev_d = lvl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) prev_q <= 1'b0;
      else        prev_q <= prev_d;
   end

   assign rise = lvl & ~prev_q;

endmodule

// File: rtl/freq_ratio_detect.sv
// -----------------------------------------------------------------------------
// freq_ratio_detect
// Measures the period and high time of a divided clock (div_in) in base-clock
// cycles and declares lock after LOCK_CNT consecutive equal periods.
// Build option FREQ_DET_SYNC_EN adds a 2-flop input synchronizer (see
// freq_edge_sync).
//
// Parameters
//   CNT_W     counter width, 4..16
//   LOCK_CNT  consecutive matching periods for lock, 1..7
//
// Ports
//   clk           in  base clock, rising edge
//   reset         in  asynchronous, active-low reset
//   enable        in  measurement enable
//   div_in        in  divided clock under measurement
//   period        out clk cycles between the last two rises of div_in
//   high_time     out clk cycles div_in was high within that period
//   period_valid  out one-cycle pulse when period/high_time update
//   locked        out lock indication
//   overflow      out one-cycle pulse when the period counter saturates
//   mismatch      out one-cycle pulse on a changed period while locked
// -----------------------------------------------------------------------------
module freq_ratio_detect
   import freq_det_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int LOCK_CNT = DEF_LOCK_CNT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             div_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             overflow,
   output logic             mismatch
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       LOCK_TGT = 3'(LOCK_CNT);

   logic lvl, rise;

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [CNT_W-1:0] hcnt_q,   hcnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q,   high_d;
   logic [2:0]       match_q,  match_d;
   logic             first_q,  first_d;
   logic             pv_q,     pv_d;
   logic             locked_q, locked_d;
   logic             ovf_q,    ovf_d;
   logic             mis_q,    mis_d;

   freq_edge_sync u_edge (
      .clk   (clk),
      .reset (reset),
      .din   (div_in),
      .lvl   (lvl),
      .rise  (rise)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hcnt_d   = hcnt_q;
      period_d = period_q;
      high_d   = high_q;
      match_d  = match_q;
      first_d  = first_q;
      locked_d = locked_q;
      pv_d     = 1'b0;
      ovf_d    = 1'b0;
      mis_d    = 1'b0;

      // Free-running saturating counters, restarted by every rise.
      if (rise) begin
         cnt_d  = CNT_ONE;
         hcnt_d = CNT_ONE;
      end else begin
         if (cnt_q != CNT_MAX)          cnt_d  = cnt_q + CNT_ONE;
         if (lvl && hcnt_q != CNT_MAX)  hcnt_d = hcnt_q + CNT_ONE;
      end

      if (!enable) begin
         state_d  = ST_IDLE;
         locked_d = 1'b0;
         match_d  = '0;
         first_d  = 1'b0;
         cnt_d    = '0;
         hcnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // First rise only opens a measurement window.
               if (rise) begin
                  state_d = ST_MEASURE;
                  first_d = 1'b1;
               end
            end
            ST_MEASURE, ST_LOCKED: begin
               if (rise) begin
                  // A rise on the saturation cycle still measures normally.
                  period_d = cnt_q;
                  high_d   = hcnt_q;
                  pv_d     = 1'b1;
                  first_d  = 1'b0;
                  // The stored period is stale on the first window after IDLE.
                  if (!first_q && cnt_q == period_q) begin
                     if (match_q != LOCK_TGT) match_d = match_q + 3'd1;
                  end else begin
                     match_d = '0;
                     if (state_q == ST_LOCKED) begin
                        mis_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = ST_MEASURE;
                     end
                  end
               end else if (cnt_q == CNT_MAX) begin
                  ovf_d    = 1'b1;
                  locked_d = 1'b0;
                  match_d  = '0;
                  first_d  = 1'b0;
                  state_d  = ST_IDLE;
               end else if (state_q == ST_MEASURE && match_q == LOCK_TGT) begin
                  // Lock is declared the cycle after the qualifying period_valid.
                  state_d  = ST_LOCKED;
                  locked_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hcnt_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         match_q  <= '0;
         first_q  <= 1'b0;
         pv_q     <= 1'b0;
         locked_q <= 1'b0;
         ovf_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hcnt_q   <= hcnt_d;
         period_q <= period_d;
         high_q   <= high_d;
         match_q  <= match_d;
         first_q  <= first_d;
         pv_q     <= pv_d;
         locked_q <= locked_d;
         ovf_q    <= ovf_d;
         mis_q    <= mis_d;
      end
   end

   assign period       = period_q;
   assign high_time    = high_q;
   assign period_valid = pv_q;
   assign locked       = locked_q;
   assign overflow     = ovf_q;
   assign mismatch     = mis_q;

endmodule

// File: doc/freq_ratio_detect.md
FREQ_RATIO_DETECT -- requirements
Module: freq_ratio_detect

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the period and high-time counters (legal range 4..16).
REQ-002 SHALL have parameter LOCK_CNT, default 2: number of consecutive matching periods required for lock (legal range 1..7).
REQ-003 SHALL have port clk, input, 1: single base clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: measurement enable.
REQ-006 SHALL have port div_in, input, 1: divided clock under measurement.
REQ-007 SHALL have port period, output, CNT_W: clk cycles between the last two rising edges of div_in.
REQ-008 SHALL have port high_time, output, CNT_W: clk cycles div_in was high within that period.
REQ-009 SHALL have port period_valid, output, 1: one-cycle pulse when period and high_time update.
REQ-010 SHALL have port locked, output, 1: LOCK_CNT consecutive equal periods seen.
REQ-011 SHALL have port overflow, output, 1: one-cycle pulse when the period counter saturates.
REQ-012 SHALL have port mismatch, output, 1: one-cycle pulse when a period differs from the previous period while locked.

Function
REQ-013 SHALL detect a rise when the sampled div_in is 1 and its previous sample is 0.
REQ-014 SHALL implement the states IDLE, MEASURE and LOCKED.
REQ-015 SHALL, in IDLE with enable=1, move to MEASURE on the first rise; no period_valid is produced for that rise.
REQ-016 SHALL, on each rise, load cnt=1 and load hcnt=1 when the sampled level is 1.
REQ-017 SHALL, on each non-rise cycle, increment cnt and increment hcnt when the sampled level is 1.
REQ-018 SHALL, on every rise in MEASURE or LOCKED, register period<=cnt and high_time<=hcnt, and pulse period_valid the following cycle.
REQ-019 SHALL keep a match counter: it increments (saturating at LOCK_CNT) when the new period equals the previous period, and clears otherwise; the first period after IDLE always clears it.
REQ-020 SHALL, when the match counter reaches LOCK_CNT, enter LOCKED with locked=1, visible one cycle after that period_valid.
REQ-021 SHALL, on an unequal period in LOCKED, pulse mismatch, drive locked=0, clear the match counter, return to MEASURE, and still update period.
REQ-022 SHALL, when cnt reaches 2^CNT_W-1 with no rise, pulse overflow, hold cnt saturated, drive locked=0, go to IDLE, and hold period and high_time.
REQ-023 SHALL, when enable=0, go to IDLE, clear locked and the match counter, and hold period and high_time; period_valid, overflow and mismatch stay 0.
REQ-024 SHALL give a rise coincident with saturation priority: measure the rise normally and suppress the overflow pulse.

Reset
REQ-025 SHALL, on reset low, asynchronously force state=IDLE, period=0, high_time=0, period_valid=0, locked=0, overflow=0, mismatch=0, all counters=0, and edge/sync flops=0.
REQ-026 SHALL resume from IDLE after reset deassertion mid-measurement, with no stale period reported.

Configuration
REQ-027 SHALL, with FREQ_DET_SYNC_EN defined, pass div_in through a 2-flop synchronizer before edge detection, adding 2 cycles of latency with the period value unchanged.
REQ-028 SHALL, without FREQ_DET_SYNC_EN, sample div_in by the single edge-detect flop only, requiring div_in synchronous to clk.

Structure
REQ-029 SHALL place the state enum type and the default CNT_W and LOCK_CNT constants in shared package freq_det_pkg.
REQ-030 SHALL place the synchronizer and rise detection in sub-module freq_edge_sync, which the configuration macro controls.

Verification
REQ-031 SHALL cover: div_in toggling every cycle (div2) -> period=2, high_time=1, locked=1 one cycle after the 3rd period_valid.
REQ-032 SHALL cover: div_in as a div8 square wave (4 high/4 low) -> period=8, high_time=4, no mismatch.
REQ-033 SHALL cover: lock on div4, then switch to div8 -> one mismatch pulse, locked=0, period=8 (or the transitional value), relock after LOCK_CNT further matches.
REQ-034 SHALL cover: CNT_W=4 with div_in held low after lock -> overflow pulse 15 cycles after the last rise, locked=0, state IDLE, period held at 4.
REQ-035 SHALL cover: reset asserted mid-period while locked on div4 -> all outputs 0 immediately; after release, first period_valid only at the 2nd rise.
REQ-036 SHALL cover: enable dropped while locked, then restored -> locked=0, period held, fresh lock sequence required.
